// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and constants for the sonar sampling slice.
// Contents: FSM state enum, WAIT_BUSY cycle limit, driver distance width.
// No ports; imported with "import sonar_pkg::*;".
package sonar_pkg;

  // Distance width delivered by sonar_driver and consumed downstream.
  localparam int DIST_W = 8;

  // Cycles the driver may keep ready high after a request before we give up.
  localparam int BUSY_LIMIT = 4;
  localparam int BUSY_W     = $clog2(BUSY_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/sonar_avg.sv
// sonar_avg: power-of-two moving average over 2^AVG_LOG2 distance samples.
// Ports: clk, rst_n (async active-low), in_valid/in_data (sample to accept),
//        out_data (average that results from accepting in_data, combinational).
module sonar_avg
  import sonar_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DIST_W-1:0] in_data,
  output logic [DIST_W-1:0] out_data
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = DIST_W + AVG_LOG2;

  logic [DIST_W-1:0] ring_q [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic              primed_q;

  // The first sample fills every slot, so the average starts at that sample
  // instead of ramping up from zero. Afterwards the slot at wp_q is the oldest.
  always_comb begin
    if (primed_q) begin
      sum_d = sum_q - SUM_W'(ring_q[wp_q]) + SUM_W'(in_data);
    end else begin
      sum_d = SUM_W'(in_data) << AVG_LOG2;
    end
    wp_d     = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    // Caller registers this the same cycle it asserts in_valid.
    out_data = DIST_W'(sum_d >> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      sum_q    <= '0;
      wp_q     <= '0;
      primed_q <= 1'b0;
    end else if (in_valid) begin
      sum_q <= sum_d;
      if (!primed_q) begin
        for (int i = 0; i < DEPTH; i++) ring_q[i] <= in_data;
        wp_q     <= '0;
        primed_q <= 1'b1;
      end else begin
        ring_q[wp_q] <= in_data;
        wp_q         <= wp_d;
      end
    end
  end

endmodule

// File: rtl/sonar_sampler.sv
// sonar_sampler: periodic measure scheduler and post-processor for sonar_driver.
// Ports: clk, rst_n (async active-low), enable; measure/sonar_ready/sonar_distance
//        handshake with the driver; dist_out/dist_valid/near/no_echo/fault results.
// Build option: define SONAR_SAMPLER_AVG_EN to smooth dist_out with sonar_avg.
module sonar_sampler
  import sonar_pkg::*;
#(
  parameter int          FREQ        = 50_000_000,
  parameter int          SAMPLE_HZ   = 10,
  parameter int          WDOG_CYCLES = FREQ / 20,
  parameter int          AVG_LOG2    = 2,
  parameter logic [7:0]  NEAR_THRESH = 8'd20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              measure,
  input  logic              sonar_ready,
  input  logic [DIST_W-1:0] sonar_distance,
  output logic [DIST_W-1:0] dist_out,
  output logic              dist_valid,
  output logic              near,
  output logic              no_echo,
  output logic              fault
);

  localparam int PERIOD = FREQ / SAMPLE_HZ;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int WD_W   = $clog2(WDOG_CYCLES + 1);

  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("sonar_sampler: AVG_LOG2 must be within 0..4");
  end

  // ---------------------------------------------------------------------------
  // Sample-rate counter. tick_q is registered, so the FSM sees it one cycle
  // after the count hits zero and measure follows one cycle after that.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = CNT_W'(PERIOD - 1);
    end else if (cnt_q == '0) begin
      cnt_d  = CNT_W'(PERIOD - 1);
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= CNT_W'(PERIOD - 1);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result path: either smoothed or raw sample.
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [DIST_W-1:0] sample_q;
  logic [DIST_W-1:0] new_dist;

`ifdef SONAR_SAMPLER_AVG_EN
  logic avg_vld;
  assign avg_vld = (state_q == ST_CAPTURE) && (sample_q != '0);

  sonar_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (avg_vld),
    .in_data  (sample_q),
    .out_data (new_dist)
  );
`else
  assign new_dist = sample_q;
`endif

  // ---------------------------------------------------------------------------
  // Measurement FSM. Ticks arriving outside IDLE are simply not looked at.
  // ---------------------------------------------------------------------------
  logic [BUSY_W-1:0] bc_q;
  logic [WD_W-1:0]   wd_q;
  logic              measure_q, dist_valid_q, near_q, no_echo_q, fault_q;
  logic [DIST_W-1:0] dist_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sample_q     <= '0;
      bc_q         <= '0;
      wd_q         <= '0;
      measure_q    <= 1'b0;
      dist_out_q   <= '0;
      dist_valid_q <= 1'b0;
      near_q       <= 1'b0;
      no_echo_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      measure_q    <= 1'b0;
      dist_valid_q <= 1'b0;
      no_echo_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick_q && sonar_ready) begin
            state_q   <= ST_FIRE;
            measure_q <= 1'b1;
          end
        end
        ST_FIRE: begin
          state_q <= ST_WAIT_BUSY;
          bc_q    <= '0;
        end
        ST_WAIT_BUSY: begin
          if (!sonar_ready) begin
            state_q <= ST_WAIT_DONE;
            wd_q    <= '0;
          end else if (bc_q == BUSY_W'(BUSY_LIMIT - 1)) begin
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            bc_q <= bc_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (sonar_ready) begin
            sample_q <= sonar_distance;
            state_q  <= ST_CAPTURE;
          end else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_CAPTURE: begin
          // A zero distance means the driver heard nothing; keep the last
          // good result rather than reporting an object at zero range.
          if (sample_q == '0) begin
            no_echo_q <= 1'b1;
          end else begin
            dist_out_q   <= new_dist;
            dist_valid_q <= 1'b1;
            near_q       <= (new_dist < NEAR_THRESH);
            fault_q      <= 1'b0;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign measure    = measure_q;
  assign dist_out   = dist_out_q;
  assign dist_valid = dist_valid_q;
  assign near       = near_q;
  assign no_echo    = no_echo_q;
  assign fault      = fault_q;

endmodule
